axis_pattern_master: RTL and testbench
======================================

AXIS_PATTERN_MASTER -- requirements
Module: axis_pattern_master

Interface
REQ-001 Parameter TDATA_WIDTH, default 24: m_axis_tdata width; SHALL be a multiple of 8, range 8..64.
REQ-002 Parameter H_ACTIVE, default 640: beats per line; SHALL be in range 2..4095.
REQ-003 Parameter V_ACTIVE, default 480: lines per frame; SHALL be in range 1..4095.
REQ-004 Parameter NUM_FRAMES, default 1: frames to emit before done; 0 means continuous.
REQ-005 aclk  in  1  sole clock; all logic rising-edge.
REQ-006 aresetn  in  1  reset, asynchronous, active-low.
REQ-007 enable  in  1  start/continue request.
REQ-008 mode  in  2  pattern select, sampled at frame start.
REQ-009 m_axis_tvalid  out  1  beat valid.
REQ-010 m_axis_tdata  out  TDATA_WIDTH  pixel data.
REQ-011 m_axis_tkeep  out  TDATA_WIDTH/8  byte enables.
REQ-012 m_axis_tlast  out  1  end of line.
REQ-013 m_axis_tuser  out  1  start of frame.
REQ-014 m_axis_tready  in  1  downstream ready.
REQ-015 done  out  1  NUM_FRAMES frames completed.
REQ-016 frame_cnt  out  16  completed-frame count.

Function
REQ-017 FSM states: IDLE, RUN, DONE.
REQ-018 IDLE->RUN when enable=1; first beat has tvalid=1 on the following cycle.
REQ-019 A beat completes on a cycle with tvalid=1 and tready=1; x advances 0..H_ACTIVE-1, then wraps to 0 and y increments; y wraps after V_ACTIVE-1.
REQ-020 tvalid SHALL NOT depend combinationally on tready; tdata/tkeep/tlast/tuser SHALL hold stable while tvalid=1 and tready=0.
REQ-021 tuser=1 only on beat x=0, y=0; tlast=1 only on beats with x=H_ACTIVE-1; tkeep all ones on every beat.
REQ-022 mode is latched when entering frame start (x=0, y=0) and held for the whole frame.
REQ-023 mode 0: tdata = y*H_ACTIVE+x, zero-extended or truncated to TDATA_WIDTH.
REQ-024 mode 1 (colour bars): bar = (x*8)/H_ACTIVE (0..7); byte lane k = 8'hFF if bar bit (k mod 3) is set, else 8'h00.
REQ-025 mode 2 (checkerboard): all ones if x[0]^y[0]=1, else all zeros.
REQ-026 mode 3 is reserved and SHALL behave as mode 0.
REQ-027 End of frame (last beat accepted): frame_cnt increments, saturating at 16'hFFFF.
REQ-028 After end of frame, if NUM_FRAMES!=0 and frame_cnt reaches NUM_FRAMES: go to DONE, tvalid=0, done=1; done holds until reset.
REQ-029 Otherwise, if enable=1: start the next frame with no idle cycle. If enable=0: go to IDLE with tvalid=0.
REQ-030 enable deasserted mid-frame SHALL NOT truncate the frame; the frame completes, then the FSM goes to IDLE.
REQ-031 In DONE, enable is ignored.

Reset
REQ-032 While aresetn=0, outputs SHALL be immediately: tvalid=0, tdata=0, tkeep=0, tlast=0, tuser=0, done=0, frame_cnt=0; FSM in IDLE; x=y=0.
REQ-033 Reset mid-frame abandons the partial frame; the next frame after release starts at x=0, y=0 with tuser=1.

Structure
REQ-034 Package axis_pattern_pkg SHALL hold the mode constants (PAT_INCR, PAT_BARS, PAT_CHECK) and the FSM state encoding.
REQ-035 Sub-module axis_pattern_pixel SHALL compute tdata combinationally from x, y and the latched mode; the top holds the FSM, counters and output registers.

Verification
REQ-036 Benches SHALL use H_ACTIVE=4, V_ACTIVE=2, TDATA_WIDTH=24 unless stated otherwise, and SHALL cover the following scenarios.
REQ-037 Scenario 1: NUM_FRAMES=1, mode=0, tready=1, enable pulsed -> 8 beats with tdata 0..7; tuser on beat 0; tlast on beats 3 and 7; then done=1, frame_cnt=1.
REQ-038 Scenario 2: tready=0 for 6 cycles at beat 2 -> tdata=2 held stable with tvalid=1; no beat lost or duplicated.
REQ-039 Scenario 3: mode=1 with H_ACTIVE=8 -> lane0 = 00,FF,00,FF,00,FF,00,FF across x=0..7; mode changed mid-frame takes effect only on the next frame.
REQ-040 Scenario 4: NUM_FRAMES=0, enable=1 for 3 frames, then enable=0 at beat 5 of frame 4 -> frame 4 completes (8 beats), FSM returns to IDLE, frame_cnt=4, done=0.
REQ-041 Scenario 5: aresetn=0 asserted at beat 3 -> outputs zero the same cycle; after release with enable=1, the first beat has tdata=0, tuser=1.
REQ-042 Scenario 6: mode=2, TDATA_WIDTH=32 -> tdata = 0, FFFFFFFF, 0, FFFFFFFF on y=0 and the inverse on y=1; tkeep=4'hF on every beat.

Source files
------------

// File: rtl/axis_pattern_pkg.sv
// Shared constants for the AXI4-Stream test-pattern master: pattern selects,
// coordinate width and the frame FSM encoding.
package axis_pattern_pkg;

    // Wide enough for any H_ACTIVE/V_ACTIVE up to 4095.
    localparam int unsigned CoordW = 12;

    localparam logic [1:0] PAT_INCR  = 2'd0;
    localparam logic [1:0] PAT_BARS  = 2'd1;
    localparam logic [1:0] PAT_CHECK = 2'd2;
    localparam logic [1:0] PAT_RSVD  = 2'd3;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

endpackage

// File: rtl/axis_pattern_pixel.sv
// Combinational pixel generator: maps (x, y, mode) to one tdata word.
// Mode 0 and the reserved mode give an incrementing index; 1 is colour bars; 2 is a checkerboard.
module axis_pattern_pixel
    import axis_pattern_pkg::*;
#(
    parameter int unsigned TDATA_WIDTH = 24,
    parameter int unsigned H_ACTIVE    = 640
) (
    input  logic [CoordW-1:0]      x,
    input  logic [CoordW-1:0]      y,
    input  logic [1:0]             mode,
    output logic [TDATA_WIDTH-1:0] tdata
);

    localparam int unsigned NumLanes = TDATA_WIDTH / 8;
    localparam logic [CoordW+2:0] HDiv = (CoordW + 3)'(H_ACTIVE);

    logic [TDATA_WIDTH-1:0] incr_data;
    logic [TDATA_WIDTH-1:0] bars_data;
    logic [TDATA_WIDTH-1:0] chk_data;
    logic [CoordW+2:0]      x_times8;
    logic [2:0]             bar;

    // Arithmetic modulo 2^TDATA_WIDTH equals truncating the full-width index.
    assign incr_data = TDATA_WIDTH'(y) * TDATA_WIDTH'(H_ACTIVE) + TDATA_WIDTH'(x);

    assign x_times8 = {x, 3'b000};
    assign bar      = 3'(x_times8 / HDiv);

    always_comb begin
        bars_data = '0;
        for (int k = 0; k < NumLanes; k++) begin
            bars_data[k*8 +: 8] = bar[2'(k % 3)] ? 8'hFF : 8'h00;
        end
    end

    assign chk_data = {TDATA_WIDTH{x[0] ^ y[0]}};

    always_comb begin
        case (mode)
            PAT_INCR:  tdata = incr_data;
            PAT_BARS:  tdata = bars_data;
            PAT_CHECK: tdata = chk_data;
            default:   tdata = incr_data;
        endcase
    end

endmodule

// File: rtl/axis_pattern_master.sv
// AXI4-Stream video test-pattern master: emits H_ACTIVE x V_ACTIVE frames with
// tuser at start of frame and tlast at end of line, optionally stopping after NUM_FRAMES.
module axis_pattern_master
    import axis_pattern_pkg::*;
#(
    parameter int unsigned TDATA_WIDTH = 24,
    parameter int unsigned H_ACTIVE    = 640,
    parameter int unsigned V_ACTIVE    = 480,
    parameter int unsigned NUM_FRAMES  = 1
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic                     enable,
    input  logic [1:0]               mode,
    output logic                     m_axis_tvalid,
    output logic [TDATA_WIDTH-1:0]   m_axis_tdata,
    output logic [TDATA_WIDTH/8-1:0] m_axis_tkeep,
    output logic                     m_axis_tlast,
    output logic                     m_axis_tuser,
    input  logic                     m_axis_tready,
    output logic                     done,
    output logic [15:0]              frame_cnt
);

    localparam int unsigned KeepW = TDATA_WIDTH / 8;
    localparam logic [CoordW-1:0] XLast = CoordW'(H_ACTIVE - 1);
    localparam logic [CoordW-1:0] YLast = CoordW'(V_ACTIVE - 1);

    state_e                 state_q, state_d;
    logic [CoordW-1:0]      x_q, x_d;
    logic [CoordW-1:0]      y_q, y_d;
    logic [1:0]             mode_q, mode_d;
    logic                   tvalid_q, tvalid_d;
    logic [TDATA_WIDTH-1:0] tdata_q, tdata_d;
    logic [KeepW-1:0]       tkeep_q, tkeep_d;
    logic                   tlast_q, tlast_d;
    logic                   tuser_q, tuser_d;
    logic                   done_q, done_d;
    logic [15:0]            frame_cnt_q, frame_cnt_d;

    logic                   load_beat;
    logic                   drop_beat;
    logic [TDATA_WIDTH-1:0] pix_data;

    // Pixel is computed for the coordinates being loaded, so the output register
    // always holds the beat currently on the bus.
    axis_pattern_pixel #(
        .TDATA_WIDTH(TDATA_WIDTH),
        .H_ACTIVE   (H_ACTIVE)
    ) u_pixel (
        .x    (x_d),
        .y    (y_d),
        .mode (mode_d),
        .tdata(pix_data)
    );

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        mode_d      = mode_q;
        tvalid_d    = tvalid_q;
        tdata_d     = tdata_q;
        tkeep_d     = tkeep_q;
        tlast_d     = tlast_q;
        tuser_d     = tuser_q;
        done_d      = done_q;
        frame_cnt_d = frame_cnt_q;
        load_beat   = 1'b0;
        drop_beat   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (enable) begin
                    state_d   = StRun;
                    x_d       = '0;
                    y_d       = '0;
                    mode_d    = mode;
                    load_beat = 1'b1;
                end
            end
            StRun: begin
                if (tvalid_q && m_axis_tready) begin
                    if (x_q != XLast) begin
                        x_d       = x_q + CoordW'(1);
                        load_beat = 1'b1;
                    end else if (y_q != YLast) begin
                        x_d       = '0;
                        y_d       = y_q + CoordW'(1);
                        load_beat = 1'b1;
                    end else begin
                        x_d = '0;
                        y_d = '0;
                        if (frame_cnt_q != 16'hFFFF) begin
                            frame_cnt_d = frame_cnt_q + 16'd1;
                        end
                        if (NUM_FRAMES != 0 && 32'(frame_cnt_d) == NUM_FRAMES) begin
                            state_d   = StDone;
                            done_d    = 1'b1;
                            drop_beat = 1'b1;
                        end else if (enable) begin
                            // Back-to-back frame: re-sample mode at the new frame start.
                            mode_d    = mode;
                            load_beat = 1'b1;
                        end else begin
                            state_d   = StIdle;
                            drop_beat = 1'b1;
                        end
                    end
                end
            end
            StDone: begin
                state_d = StDone;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (load_beat) begin
            tvalid_d = 1'b1;
            tdata_d  = pix_data;
            tkeep_d  = '1;
            tlast_d  = (x_d == XLast);
            tuser_d  = (x_d == '0) && (y_d == '0);
        end else if (drop_beat) begin
            tvalid_d = 1'b0;
            tdata_d  = '0;
            tkeep_d  = '0;
            tlast_d  = 1'b0;
            tuser_d  = 1'b0;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= StIdle;
            x_q         <= '0;
            y_q         <= '0;
            mode_q      <= PAT_INCR;
            tvalid_q    <= 1'b0;
            tdata_q     <= '0;
            tkeep_q     <= '0;
            tlast_q     <= 1'b0;
            tuser_q     <= 1'b0;
            done_q      <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            mode_q      <= mode_d;
            tvalid_q    <= tvalid_d;
            tdata_q     <= tdata_d;
            tkeep_q     <= tkeep_d;
            tlast_q     <= tlast_d;
            tuser_q     <= tuser_d;
            done_q      <= done_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tdata  = tdata_q;
    assign m_axis_tkeep  = tkeep_q;
    assign m_axis_tlast  = tlast_q;
    assign m_axis_tuser  = tuser_q;
    assign done          = done_q;
    assign frame_cnt     = frame_cnt_q;

endmodule

// File: tb/tb_axis_pattern_master.sv
// Directed bench for axis_pattern_master: four instances cover single-frame, back-pressure,
// reset, colour bars with mid-frame mode change, continuous streaming and checkerboard.
module tb_axis_pattern_master;

    logic aclk = 1'b0;
    logic aresetn = 1'b1;
    always #5 aclk = ~aclk;

    int tests_run = 0;
    int tests_failed = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Hand-derived colour bars for H_ACTIVE=8: bar index equals x, lane k lit by bar bit k.
    localparam logic [23:0] BarsExp [8] = '{24'h000000, 24'h0000FF, 24'h00FF00, 24'h00FFFF,
                                            24'hFF0000, 24'hFF00FF, 24'hFFFF00, 24'hFFFFFF};
    localparam logic [31:0] CheckExp [8] = '{32'h0, 32'hFFFFFFFF, 32'h0, 32'hFFFFFFFF,
                                             32'hFFFFFFFF, 32'h0, 32'hFFFFFFFF, 32'h0};

    // a: H4 V2 W24, one frame
    logic a_en = 0, a_tready = 1, a_tvalid, a_tlast, a_tuser, a_done;
    logic [1:0] a_mode = 0;
    logic [23:0] a_tdata;
    logic [2:0] a_tkeep;
    logic [15:0] a_fcnt;
    // b: H8 V2 W24, continuous
    logic b_en = 0, b_tready = 1, b_tvalid, b_tlast, b_tuser, b_done;
    logic [1:0] b_mode = 0;
    logic [23:0] b_tdata;
    logic [2:0] b_tkeep;
    logic [15:0] b_fcnt;
    // c: H4 V2 W24, continuous
    logic c_en = 0, c_tready = 1, c_tvalid, c_tlast, c_tuser, c_done;
    logic [1:0] c_mode = 0;
    logic [23:0] c_tdata;
    logic [2:0] c_tkeep;
    logic [15:0] c_fcnt;
    // d: H4 V2 W32, one frame
    logic d_en = 0, d_tready = 1, d_tvalid, d_tlast, d_tuser, d_done;
    logic [1:0] d_mode = 0;
    logic [31:0] d_tdata;
    logic [3:0] d_tkeep;
    logic [15:0] d_fcnt;

    axis_pattern_master #(.TDATA_WIDTH(24), .H_ACTIVE(4), .V_ACTIVE(2), .NUM_FRAMES(1)) u_dut_a (
        .aclk(aclk), .aresetn(aresetn), .enable(a_en), .mode(a_mode),
        .m_axis_tvalid(a_tvalid), .m_axis_tdata(a_tdata), .m_axis_tkeep(a_tkeep),
        .m_axis_tlast(a_tlast), .m_axis_tuser(a_tuser), .m_axis_tready(a_tready),
        .done(a_done), .frame_cnt(a_fcnt)
    );
    axis_pattern_master #(.TDATA_WIDTH(24), .H_ACTIVE(8), .V_ACTIVE(2), .NUM_FRAMES(0)) u_dut_b (
        .aclk(aclk), .aresetn(aresetn), .enable(b_en), .mode(b_mode),
        .m_axis_tvalid(b_tvalid), .m_axis_tdata(b_tdata), .m_axis_tkeep(b_tkeep),
        .m_axis_tlast(b_tlast), .m_axis_tuser(b_tuser), .m_axis_tready(b_tready),
        .done(b_done), .frame_cnt(b_fcnt)
    );
    axis_pattern_master #(.TDATA_WIDTH(24), .H_ACTIVE(4), .V_ACTIVE(2), .NUM_FRAMES(0)) u_dut_c (
        .aclk(aclk), .aresetn(aresetn), .enable(c_en), .mode(c_mode),
        .m_axis_tvalid(c_tvalid), .m_axis_tdata(c_tdata), .m_axis_tkeep(c_tkeep),
        .m_axis_tlast(c_tlast), .m_axis_tuser(c_tuser), .m_axis_tready(c_tready),
        .done(c_done), .frame_cnt(c_fcnt)
    );
    axis_pattern_master #(.TDATA_WIDTH(32), .H_ACTIVE(4), .V_ACTIVE(2), .NUM_FRAMES(1)) u_dut_d (
        .aclk(aclk), .aresetn(aresetn), .enable(d_en), .mode(d_mode),
        .m_axis_tvalid(d_tvalid), .m_axis_tdata(d_tdata), .m_axis_tkeep(d_tkeep),
        .m_axis_tlast(d_tlast), .m_axis_tuser(d_tuser), .m_axis_tready(d_tready),
        .done(d_done), .frame_cnt(d_fcnt)
    );

    // One enable pulse, then a single mode-0 frame on instance a, optionally stalling one beat.
    task automatic run_a(input string name, input int stall_at, input int stall_len);
        int n = 0;
        int stalls = 0;
        a_tready = 1'b1;
        a_en = 1'b1;
        @(negedge aclk);
        a_en = 1'b0;
        for (int cyc = 0; cyc < 64 && n < 8; cyc++) begin
            check_eq({name, "_tvalid"}, a_tvalid, 1);
            if (n == stall_at && stalls < stall_len) begin
                a_tready = 1'b0;
                stalls++;
                check_eq({name, "_hold_data"}, a_tdata, stall_at);
            end else begin
                a_tready = 1'b1;
                check_eq({name, "_data"}, a_tdata, n);
                check_eq({name, "_tuser"}, a_tuser, n == 0);
                check_eq({name, "_tlast"}, a_tlast, n % 4 == 3);
                check_eq({name, "_tkeep"}, a_tkeep, 3'h7);
                n++;
            end
            @(negedge aclk);
        end
        check_eq({name, "_beats"}, n, 8);
        check_eq({name, "_stalls"}, stalls, stall_len);
        check_eq({name, "_end_tvalid"}, a_tvalid, 0);
        check_eq({name, "_done"}, a_done, 1);
        check_eq({name, "_fcnt"}, a_fcnt, 1);
    endtask

    int n;
    int gaps;
    int found;

    initial begin
        #2 aresetn = 1'b0;
        #1;
        check_eq("rst_tvalid", a_tvalid, 0);
        check_eq("rst_tdata", a_tdata, 0);
        check_eq("rst_tkeep", a_tkeep, 0);
        check_eq("rst_tlast", a_tlast, 0);
        check_eq("rst_tuser", a_tuser, 0);
        check_eq("rst_done", a_done, 0);
        check_eq("rst_fcnt", a_fcnt, 0);
        @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);
        check_eq("idle_tvalid", a_tvalid, 0);

        // Scenario 1: plain frame, then enable ignored in DONE
        run_a("s1", -1, 0);
        a_en = 1'b1;
        repeat (3) @(negedge aclk);
        check_eq("s1_done_ignores_en", a_tvalid, 0);
        check_eq("s1_done_held", a_done, 1);
        a_en = 1'b0;

        // Scenario 2: six-cycle stall on beat 2
        aresetn = 1'b0;
        @(negedge aclk);
        aresetn = 1'b1;
        run_a("s2", 2, 6);

        // Scenario 5: reset at beat 3
        aresetn = 1'b0;
        @(negedge aclk);
        aresetn = 1'b1;
        a_tready = 1'b1;
        a_en = 1'b1;
        @(negedge aclk);
        a_en = 1'b0;
        found = 0;
        for (int cyc = 0; cyc < 20 && found == 0; cyc++) begin
            @(negedge aclk);
            if (a_tvalid && a_tdata == 24'd3) found = 1;
        end
        check_eq("s5_reach_beat3", found, 1);
        check_eq("s5_beat3_tlast", a_tlast, 1);
        aresetn = 1'b0;
        #1;
        check_eq("s5_rst_tvalid", a_tvalid, 0);
        check_eq("s5_rst_tdata", a_tdata, 0);
        check_eq("s5_rst_tkeep", a_tkeep, 0);
        check_eq("s5_rst_tlast", a_tlast, 0);
        check_eq("s5_rst_tuser", a_tuser, 0);
        check_eq("s5_rst_done", a_done, 0);
        @(negedge aclk);
        aresetn = 1'b1;
        a_en = 1'b1;
        @(negedge aclk);
        a_en = 1'b0;
        check_eq("s5_restart_tvalid", a_tvalid, 1);
        check_eq("s5_restart_tdata", a_tdata, 0);
        check_eq("s5_restart_tuser", a_tuser, 1);

        // Scenario 3: bars on H=8, mode switched to 0 mid-frame, two frames then stop
        b_mode = 2'd1;
        b_tready = 1'b1;
        b_en = 1'b1;
        n = 0;
        gaps = 0;
        @(negedge aclk);
        for (int cyc = 0; cyc < 100 && n < 32; cyc++) begin
            if (b_tvalid) begin
                if (n < 16) begin
                    check_eq("s3_bars", b_tdata, BarsExp[n % 8]);
                    check_eq("s3_lane0", b_tdata[7:0], (n % 2 == 1) ? 8'hFF : 8'h00);
                end else begin
                    check_eq("s3_incr", b_tdata, n % 16);
                end
                check_eq("s3_tuser", b_tuser, n % 16 == 0);
                check_eq("s3_tlast", b_tlast, n % 8 == 7);
                n++;
                if (n == 6) b_mode = 2'd0;
                if (n == 20) b_en = 1'b0;
            end else if (n > 0) begin
                gaps++;
            end
            @(negedge aclk);
        end
        check_eq("s3_beats", n, 32);
        check_eq("s3_gaps", gaps, 0);
        repeat (2) @(negedge aclk);
        check_eq("s3_idle_tvalid", b_tvalid, 0);
        check_eq("s3_fcnt", b_fcnt, 2);
        check_eq("s3_done", b_done, 0);

        // Scenario 4: continuous, enable dropped at beat 5 of frame 4
        c_mode = 2'd0;
        c_tready = 1'b1;
        c_en = 1'b1;
        n = 0;
        gaps = 0;
        @(negedge aclk);
        for (int cyc = 0; cyc < 100 && n < 32; cyc++) begin
            if (c_tvalid) begin
                check_eq("s4_data", c_tdata, n % 8);
                check_eq("s4_tuser", c_tuser, n % 8 == 0);
                check_eq("s4_tlast", c_tlast, n % 4 == 3);
                if (n == 24) check_eq("s4_fcnt_f3", c_fcnt, 3);
                if (n == 29) c_en = 1'b0;
                n++;
            end else if (n > 0) begin
                gaps++;
            end
            @(negedge aclk);
        end
        check_eq("s4_beats", n, 32);
        check_eq("s4_gaps", gaps, 0);
        check_eq("s4_end_tvalid", c_tvalid, 0);
        repeat (3) @(negedge aclk);
        check_eq("s4_idle_tvalid", c_tvalid, 0);
        check_eq("s4_fcnt", c_fcnt, 4);
        check_eq("s4_done", c_done, 0);

        // Scenario 6: checkerboard at 32 bits
        d_mode = 2'd2;
        d_tready = 1'b1;
        d_en = 1'b1;
        n = 0;
        @(negedge aclk);
        d_en = 1'b0;
        for (int cyc = 0; cyc < 40 && n < 8; cyc++) begin
            if (d_tvalid) begin
                check_eq("s6_data", d_tdata, CheckExp[n]);
                check_eq("s6_tkeep", d_tkeep, 4'hF);
                n++;
            end
            @(negedge aclk);
        end
        check_eq("s6_beats", n, 8);
        check_eq("s6_done", d_done, 1);
        check_eq("s6_fcnt", d_fcnt, 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
